// File: rtl/tm_input_sequencer.sv
// Buffers up to DEPTH 4-bit symbols and replays them to a Turing machine as setup/Next/hold, then Done.
// Optional TM_SEQ_TIMEOUT_EN: bounded wait for tm_compute_done, raising a sticky timeout flag.
module tm_input_sequencer #(
    parameter int DEPTH          = 16,
    parameter int GAP            = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] load_data,
    input  logic       load_valid,
    input  logic       clear,
    input  logic       start,
    output logic [3:0] tm_input_data,
    output logic       tm_next,
    output logic       tm_done,
    input  logic       tm_compute_done,
    output logic [4:0] count,
    output logic       busy,
    output logic       finished,
    output logic       overflow,
    output logic       timeout
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C  = 5'(DEPTH);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_NEXT, S_HOLD, S_DONE, S_WAIT} state_t;

    state_t        state;
    logic [3:0]    sym_buf [DEPTH];
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nxt;
    logic [7:0]    gap_cnt;
    logic          load_ok;
    logic          last_sym;
    logic [3:0]    first_sym;

    assign load_ok   = load_valid && (count < DEPTH_C);
    assign idx_nxt   = idx + AW'(1);
    assign last_sym  = (5'(idx) + 5'd1) >= count;
    // A load in the same cycle as start into an empty buffer is not in sym_buf yet.
    assign first_sym = (count == 5'd0) ? load_data : sym_buf[0];

`ifdef TM_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;
`else
    // TIMEOUT_CYCLES is never negative, so this is a constant 0.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            count         <= '0;
            idx           <= '0;
            gap_cnt       <= '0;
            tm_input_data <= '0;
            tm_next       <= 1'b0;
            tm_done       <= 1'b0;
            busy          <= 1'b0;
            finished      <= 1'b0;
            overflow      <= 1'b0;
`ifdef TM_SEQ_TIMEOUT_EN
            timeout       <= 1'b0;
            wait_cnt      <= '0;
`endif
        end else begin
            tm_next <= 1'b0;
            tm_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Clear takes the whole cycle: the load and any start are dropped.
                    if (clear) begin
                        count    <= '0;
                        finished <= 1'b0;
                        overflow <= 1'b0;
`ifdef TM_SEQ_TIMEOUT_EN
                        timeout  <= 1'b0;
`endif
                    end else begin
                        if (load_ok) begin
                            sym_buf[count[AW-1:0]] <= load_data;
                            count <= count + 5'd1;
                        end else if (load_valid) begin
                            overflow <= 1'b1;
                        end
                        if (start) begin
                            finished <= 1'b0;
                            busy     <= 1'b1;
                            idx      <= '0;
                            gap_cnt  <= '0;
                            if (count != 5'd0 || load_ok) begin
                                state         <= S_SETUP;
                                tm_input_data <= first_sym;
                            end else begin
                                state   <= S_DONE;
                                tm_done <= 1'b1;
                            end
                        end
                    end
                end
                S_SETUP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= S_NEXT;
                        tm_next <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                S_NEXT: state <= S_HOLD;
                S_HOLD: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (!last_sym) begin
                            idx           <= idx_nxt;
                            state         <= S_SETUP;
                            tm_input_data <= sym_buf[idx_nxt];
                        end else begin
                            state         <= S_DONE;
                            tm_done       <= 1'b1;
                            tm_input_data <= '0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_WAIT;
`ifdef TM_SEQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (tm_compute_done) begin
                        finished <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
`ifdef TM_SEQ_TIMEOUT_EN
                    end else if (wait_cnt == TO_LAST) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm_input_sequencer.sv
// Scoreboard bench for tm_input_sequencer: expected Next/Done pulses are queued at stimulus time, a monitor checks them.
module tb_tm_input_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] load_data;
    logic       load_valid, clear, start, tm_compute_done;
    logic [3:0] tm_input_data;
    logic       tm_next, tm_done;
    logic [4:0] count;
    logic       busy, finished, overflow, timeout;

    always #5 clock = ~clock;

    tm_input_sequencer #(.DEPTH(16), .GAP(4), .TIMEOUT_CYCLES(100)) dut (
        .clock(clock), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .clear(clear), .start(start), .tm_input_data(tm_input_data), .tm_next(tm_next),
        .tm_done(tm_done), .tm_compute_done(tm_compute_done), .count(count), .busy(busy),
        .finished(finished), .overflow(overflow), .timeout(timeout)
    );

    typedef struct {
        int         kind;   // 0 = Next, 1 = Done
        logic [3:0] data;
        int         cyc;
    } ev_t;

    ev_t        sb[$];
    logic [3:0] model[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         pulse_count = 0;
    logic [3:0] hist [32];
    int         hold_due = -1;
    logic [3:0] hold_data;
    logic       prev_pulse = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compares each pulse against the scoreboard and checks data stability around Next.
    always @(negedge clock) begin
        ev_t  e;
        int   act_kind;
        logic ok;
        hist[cyc & 31] = tm_input_data;
        if (reset) hold_due = -1;
        if (tm_next || tm_done) begin
            pulse_count++;
            checks++;
            if ((tm_next && tm_done) || prev_pulse) begin
                failures++;
                $display("FAIL pulse_shape cyc=%0d next=%0b done=%0b prev=%0b required single isolated pulse",
                         cyc, tm_next, tm_done, prev_pulse);
            end
            act_kind = tm_done ? 1 : 0;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d kind=%0d data=%0h required none", cyc, act_kind, tm_input_data);
            end else begin
                e = sb.pop_front();
                if (e.kind != act_kind || e.data !== tm_input_data || e.cyc != cyc) begin
                    failures++;
                    $display("FAIL pulse kind=%0d data=%0h cyc=%0d required kind=%0d data=%0h cyc=%0d",
                             act_kind, tm_input_data, cyc, e.kind, e.data, e.cyc);
                end
                if (e.kind == 0) begin
                    ok = 1'b1;
                    for (int j = 0; j <= 4; j++) if (hist[(cyc - j) & 31] !== e.data) ok = 1'b0;
                    checks++;
                    if (!ok) begin
                        failures++;
                        $display("FAIL setup_stable cyc=%0d data not held at %0h for 4 cycles before Next", cyc, e.data);
                    end
                    hold_due  = cyc + 4;
                    hold_data = e.data;
                end
            end
        end
        if (hold_due == cyc) begin
            ok = 1'b1;
            for (int j = 0; j < 4; j++) if (hist[(cyc - j) & 31] !== hold_data) ok = 1'b0;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d data not held at %0h for 4 cycles after Next", cyc, hold_data);
            end
            hold_due = -1;
        end
        prev_pulse = tm_next | tm_done;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic do_load(input logic [3:0] s);
        load_data  = s;
        load_valid = 1'b1;
        if (model.size() < 16) model.push_back(s);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model.delete();
    endtask

    // Start issued in the current cycle k: Next i at k+5+9i, Done at k+9n+1.
    task automatic do_start(input bit with_load, input logic [3:0] s);
        int k;
        k = cyc;
        if (with_load) begin
            load_data  = s;
            load_valid = 1'b1;
            if (model.size() < 16) model.push_back(s);
        end
        start = 1'b1;
        for (int i = 0; i < model.size(); i++) sb.push_back('{0, model[i], k + 5 + 9 * i});
        sb.push_back('{1, 4'h0, k + 9 * model.size() + 1});
        tick();
        start      = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic wait_sb(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain pending=%0d required 0 within %0d cycles", sb.size(), bound);
            sb.delete();
        end
    endtask

    task automatic compute_done_pulse();
        tm_compute_done = 1'b1;
        tick();
        tm_compute_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int d;
        int pc;
        reset = 1'b1; load_data = '0; load_valid = 1'b0; clear = 1'b0;
        start = 1'b0; tm_compute_done = 1'b0;
        tick(3);
        chk("rst_data", tm_input_data, 0);
        chk("rst_next_done", {tm_next, tm_done}, 0);
        chk("rst_count", count, 0);
        chk("rst_flags", {busy, finished, overflow, timeout}, 0);
        reset = 1'b0;
        tick();

        // Basic replay of 3,5,A
        do_load(4'h3); do_load(4'h5); do_load(4'hA);
        chk("load3_count", count, 3);
        do_start(1'b0, 4'h0);
        chk("replay_busy", busy, 1);
        wait_sb(200);
        chk("wait_busy", busy, 1);
        chk("wait_data_zero", tm_input_data, 0);
        compute_done_pulse();
        chk("finished_set", finished, 1);
        chk("finished_idle", busy, 0);

        // Second replay of the same string, with ignored strobes mid-replay
        do_start(1'b0, 4'h0);
        chk("restart_clears_finished", finished, 0);
        tick(2);
        start = 1'b1; tick(); start = 1'b0;
        tick(3);
        load_data = 4'hF; load_valid = 1'b1; tick(); load_valid = 1'b0;
        tick(4);
        clear = 1'b1; tick(); clear = 1'b0;
        wait_sb(200);
        chk("busy_strobes_count", count, 3);
        chk("busy_strobes_ovf", overflow, 0);
        compute_done_pulse();
        chk("replay2_finished", finished, 1);

        // Overflow on the 17th load, then clear
        do_clear();
        chk("clear_finished", finished, 0);
        for (int i = 0; i < 17; i++) do_load(4'(i));
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1);
        do_clear();
        chk("clr_count", count, 0);
        chk("clr_ovf", overflow, 0);

        // Empty start goes straight to Done
        do_start(1'b0, 4'h0);
        chk("empty_busy", busy, 1);
        wait_sb(20);
        chk("empty_data_zero", tm_input_data, 0);
        compute_done_pulse();
        chk("empty_finished", finished, 1);

        // Load and start in the same cycle
        do_start(1'b1, 4'h2);
        wait_sb(100);
        chk("ldst_count", count, 1);
        compute_done_pulse();
        chk("ldst_finished", finished, 1);

        // Reset during hold of the 2nd symbol
        do_clear();
        do_load(4'h1); do_load(4'h2); do_load(4'h3);
        k = cyc;
        do_start(1'b0, 4'h0);
        wait_until(k + 16);
        reset = 1'b1;
        sb.delete();
        tick();
        chk("abort_data", tm_input_data, 0);
        chk("abort_pulses", {tm_next, tm_done}, 0);
        chk("abort_count", count, 0);
        chk("abort_flags", {busy, finished, overflow, timeout}, 0);
        reset = 1'b0;
        model.delete();
        pc = pulse_count;
        tick(40);
        chk("abort_no_pulse", pulse_count, pc);

        // WAIT without compute_done
        do_load(4'h9);
        k = cyc;
        d = k + 10;
        do_start(1'b0, 4'h0);
        wait_sb(100);
        wait_until(d + 100);
        chk("wait100_busy", busy, 1);
        chk("wait100_timeout", timeout, 0);
        tick();
`ifdef TM_SEQ_TIMEOUT_EN
        chk("to_flag", timeout, 1);
        chk("to_busy", busy, 0);
        chk("to_finished", finished, 0);
        do_clear();
        chk("to_cleared", timeout, 0);
`else
        chk("noto_busy", busy, 1);
        chk("noto_flag", timeout, 0);
        compute_done_pulse();
        chk("noto_finished", finished, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
